// File: rtl/cle_key_pkg.sv
// Shared types and bus constants for the CLE key reader: sequencer states,
// run phases and the fixed address offsets used to step the key decoder.
package cle_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER,
        DONE
    } cle_state_e;

    typedef enum logic {
        UNLOCK,
        READ
    } cle_phase_e;

    // Unlock offsets, first access in the top nibble.
    localparam logic [15:0] UNLOCK_SEQ = {4'h2, 4'h8, 4'hA, 4'h9};
    localparam logic [3:0]  READ_OFF   = 4'h2;

    localparam logic BA13_SEL = 1'b0;
    localparam logic BA12_SEL = 1'b1;

    function automatic logic [3:0] unlock_offset(input logic [5:0] idx);
        case (idx)
            6'd0:    return UNLOCK_SEQ[15:12];
            6'd1:    return UNLOCK_SEQ[11:8];
            6'd2:    return UNLOCK_SEQ[7:4];
            6'd3:    return UNLOCK_SEQ[3:0];
            default: return READ_OFF;
        endcase
    endfunction

endpackage

// File: rtl/cle_bus_cycle.sv
// One key decoder read access: SETUP, STROBE (sser_n low), RECOVER (bus_clk pulse).
// A request held high across the ack cycle chains the next access with no gap.
module cle_bus_cycle
    import cle_key_pkg::*;
#(
    parameter int STB_CYC = 2,
    parameter int REC_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] offset,
    input  logic       sdrd,
    output logic       ack,
    output logic       sample,
    output logic       sser_n,
    output logic       ba13,
    output logic       ba12,
    output logic [3:0] ba_lo,
    output logic       br_w,
    output logic       bus_clk
);

    localparam logic [7:0] STB_LAST = 8'(STB_CYC - 1);
    localparam logic [7:0] REC_LAST = 8'(REC_CYC);

    cle_state_e state;
    logic [7:0] cnt;

    assign ba13 = BA13_SEL;
    assign br_w = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            sample  <= 1'b0;
            sser_n  <= 1'b1;
            bus_clk <= 1'b0;
            ba12    <= 1'b0;
            ba_lo   <= '0;
        end else begin
            ack     <= 1'b0;
            bus_clk <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= SETUP;
                        ba12  <= BA12_SEL;
                        ba_lo <= offset;
                    end
                end
                SETUP: begin
                    state  <= STROBE;
                    sser_n <= 1'b0;
                    cnt    <= '0;
                end
                STROBE: begin
                    if (cnt == STB_LAST) begin
                        // Sample before the decoder sees its state clock.
                        sample  <= sdrd;
                        sser_n  <= 1'b1;
                        bus_clk <= 1'b1;
                        cnt     <= '0;
                        ack     <= (REC_CYC == 0);
                        state   <= RECOVER;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RECOVER: begin
                    if (cnt == REC_LAST) begin
                        cnt <= '0;
                        if (req) begin
                            state <= SETUP;
                            ba12  <= BA12_SEL;
                            ba_lo <= offset;
                        end else begin
                            state <= IDLE;
                            ba12  <= 1'b0;
                            ba_lo <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        ack <= ((cnt + 8'd1) == REC_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cle_key_reader.sv
// Run sequencer: unlock accesses, then NBITS reads shifted MSB-first into key_data.
// Access timing lives in cle_bus_cycle; this level owns phase, counters and the word.
module cle_key_reader
    import cle_key_pkg::*;
#(
    parameter int NBITS      = 16,
    parameter int STB_CYC    = 2,
    parameter int REC_CYC    = 1,
    parameter int UNLOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] key_data,
    output logic             sser_n,
    output logic             ba13,
    output logic             ba12,
    output logic [3:0]       ba_lo,
    output logic             br_w,
    output logic             bus_clk,
    input  logic             sdrd
);

    localparam logic [5:0] U_LAST = 6'(UNLOCK_LEN - 1);
    localparam logic [5:0] B_LAST = 6'(NBITS - 1);

    // run_state uses IDLE / SETUP / DONE; SETUP means accesses are in flight.
    cle_state_e run_state;
    cle_phase_e phase, phase_nxt;
    logic [5:0] acc_cnt, acc_nxt;
    logic [5:0] bit_cnt, bit_nxt;
    logic       req, ack, sample, final_acc;
    logic [3:0] offset;

    assign final_acc = (phase == READ) && (bit_cnt == B_LAST);

    // The next access's offset is needed on the same edge that retires this one.
    always_comb begin
        phase_nxt = phase;
        acc_nxt   = acc_cnt;
        bit_nxt   = bit_cnt;
        if (ack) begin
            if (phase == UNLOCK) begin
                if (acc_cnt == U_LAST) begin
                    phase_nxt = READ;
                    bit_nxt   = '0;
                end else begin
                    acc_nxt = acc_cnt + 6'd1;
                end
            end else begin
                bit_nxt = bit_cnt + 6'd1;
            end
        end
    end

    assign offset = (phase_nxt == UNLOCK) ? unlock_offset(acc_nxt) : READ_OFF;
    assign req    = ((run_state == IDLE) && start)
                 || ((run_state == SETUP) && !(ack && final_acc));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_state <= IDLE;
            phase     <= UNLOCK;
            acc_cnt   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_data  <= '0;
        end else begin
            case (run_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        run_state <= SETUP;
                        busy      <= 1'b1;
                        key_data  <= '0;
                        phase     <= UNLOCK;
                        acc_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (ack) begin
                        if (phase == READ)
                            key_data <= (key_data << 1) | NBITS'(sample);
                        if (final_acc) begin
                            run_state <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            phase     <= UNLOCK;
                            acc_cnt   <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            phase   <= phase_nxt;
                            acc_cnt <= acc_nxt;
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    run_state <= IDLE;
                end
                default: run_state <= IDLE;
            endcase
        end
    end

    cle_bus_cycle #(
        .STB_CYC(STB_CYC),
        .REC_CYC(REC_CYC)
    ) u_bus (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .offset (offset),
        .sdrd   (sdrd),
        .ack    (ack),
        .sample (sample),
        .sser_n (sser_n),
        .ba13   (ba13),
        .ba12   (ba12),
        .ba_lo  (ba_lo),
        .br_w   (br_w),
        .bus_clk(bus_clk)
    );

endmodule

// File: tb/tb_cle_key_reader.sv
// Directed bench for cle_key_reader: default instance with a key decoder model,
// plus a NBITS=1 / STB_CYC=1 / REC_CYC=0 corner instance.
module tb_cle_key_reader;

    // Default instance: 5 cycles per access, 20 accesses, +1 for DONE.
    localparam int LAT_A = (4 + 16) * (2 + 2 + 1) + 1;
    // Corner instance: 3 cycles per access, 5 accesses, +1 for DONE.
    localparam int LAT_B = (4 + 1) * (2 + 1 + 0) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, start_a = 1'b0, sdrd_a;
    logic        busy_a, done_a, sser_n_a, ba13_a, ba12_a, br_w_a, bus_clk_a;
    logic [15:0] key_data_a;
    logic [3:0]  ba_lo_a;

    logic        rst_b = 1'b1, start_b = 1'b0, sdrd_b;
    logic        busy_b, done_b, sser_n_b, ba13_b, ba12_b, br_w_b, bus_clk_b;
    logic [0:0]  key_data_b;
    logic [3:0]  ba_lo_b;

    cle_key_reader u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .key_data(key_data_a), .sser_n(sser_n_a), .ba13(ba13_a), .ba12(ba12_a),
        .ba_lo(ba_lo_a), .br_w(br_w_a), .bus_clk(bus_clk_a), .sdrd(sdrd_a)
    );

    cle_key_reader #(.NBITS(1), .STB_CYC(1), .REC_CYC(0), .UNLOCK_LEN(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .key_data(key_data_b), .sser_n(sser_n_b), .ba13(ba13_b), .ba12(ba12_b),
        .ba_lo(ba_lo_b), .br_w(br_w_b), .bus_clk(bus_clk_b), .sdrd(sdrd_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Key decoder model: output advances only on bus_clk rising edges.
    logic [15:0] pat_a = 16'h0;
    logic        clr_a = 1'b0;
    int          pulses_a = 0;
    always @(posedge bus_clk_a or posedge clr_a)
        if (clr_a) pulses_a <= 0;
        else       pulses_a <= pulses_a + 1;
    assign sdrd_a = (pulses_a < 4)  ? 1'b1 :
                    (pulses_a < 20) ? pat_a[19 - pulses_a] : 1'b0;

    logic val_b = 1'b0;
    logic clr_b = 1'b0;
    int   pulses_b = 0;
    always @(posedge bus_clk_b or posedge clr_b)
        if (clr_b) pulses_b <= 0;
        else       pulses_b <= pulses_b + 1;
    assign sdrd_b = (pulses_b == 4) ? val_b : ~val_b;

    // Scoreboard: expected ba_lo per access, checked on each bus_clk pulse.
    logic [3:0] exp_q[$];
    int   bus_pulses_a = 0, done_cnt_a = 0, sser_low_a = 0;
    int   bus_pulses_b = 0, done_cnt_b = 0;
    logic prev_bclk_a = 1'b0, prev_bclk_b = 1'b0;

    always @(negedge clk) begin
        if (bus_clk_a && !prev_bclk_a) begin
            bus_pulses_a++;
            if (exp_q.size() == 0) check_eq("unexpected_access", exp_q.size(), 1);
            else check_eq("ba_lo", ba_lo_a, exp_q.pop_front());
            check_eq("ba12_at_pulse", ba12_a, 1);
            check_eq("sser_n_at_pulse", sser_n_a, 1);
        end
        prev_bclk_a = bus_clk_a;
        if (done_a)    done_cnt_a++;
        if (!sser_n_a) sser_low_a++;
        if (bus_clk_b && !prev_bclk_b) bus_pulses_b++;
        prev_bclk_b = bus_clk_b;
        if (done_b) done_cnt_b++;
    end

    task automatic load_exp_a();
        exp_q.delete();
        exp_q.push_back(4'h2); exp_q.push_back(4'h8);
        exp_q.push_back(4'hA); exp_q.push_back(4'h9);
        for (int i = 0; i < 16; i++) exp_q.push_back(4'h2);
    endtask

    task automatic clear_model_a(input logic [15:0] pat);
        pat_a = pat;
        clr_a = 1'b1;
        #1 clr_a = 1'b0;
    endtask

    // Full run on instance A; optionally pulse start again at cycles 10 and 40.
    task automatic run_a(input logic [15:0] pat, input bit extra_starts, input string tag);
        int lat, p0, d0;
        @(negedge clk);
        clear_model_a(pat);
        load_exp_a();
        p0 = bus_pulses_a;
        d0 = done_cnt_a;
        start_a = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq({tag, "_busy_rise"}, busy_a, 1);
        check_eq({tag, "_key_clear"}, key_data_a, 0);
        while (!done_a && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_a = extra_starts && (lat == 10 || lat == 40);
        end
        start_a = 1'b0;
        check_eq({tag, "_latency"}, lat, LAT_A);
        check_eq({tag, "_key_data"}, key_data_a, pat);
        check_eq({tag, "_busy_at_done"}, busy_a, 0);
        @(negedge clk);
        check_eq({tag, "_done_width"}, done_a, 0);
        repeat (10) @(negedge clk);
        check_eq({tag, "_access_count"}, bus_pulses_a - p0, 20);
        check_eq({tag, "_done_count"}, done_cnt_a - d0, 1);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
        check_eq({tag, "_key_hold"}, key_data_a, pat);
    endtask

    task automatic run_b(input logic v, input string tag);
        int lat, p0, d0;
        @(negedge clk);
        val_b = v;
        clr_b = 1'b1;
        #1 clr_b = 1'b0;
        p0 = bus_pulses_b;
        d0 = done_cnt_b;
        start_b = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq({tag, "_key_clear"}, key_data_b, 0);
        while (!done_b && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, lat, LAT_B);
        check_eq({tag, "_key_data"}, key_data_b, v);
        repeat (5) @(negedge clk);
        check_eq({tag, "_access_count"}, bus_pulses_b - p0, 5);
        check_eq({tag, "_done_count"}, done_cnt_b - d0, 1);
    endtask

    initial begin
        int p0, d0, s0, lat;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_sser_n", sser_n_a, 1);
        check_eq("rst_bus_clk", bus_clk_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_key_data", key_data_a, 0);
        check_eq("rst_ba12", ba12_a, 0);
        check_eq("rst_ba13", ba13_a, 0);
        check_eq("rst_ba_lo", ba_lo_a, 0);
        check_eq("rst_br_w", br_w_a, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle with no start: no bus activity.
        p0 = bus_pulses_a;
        s0 = sser_low_a;
        repeat (20) @(negedge clk);
        check_eq("idle_pulses", bus_pulses_a - p0, 0);
        check_eq("idle_sser_low", sser_low_a - s0, 0);
        check_eq("idle_busy", busy_a, 0);

        run_a(16'hA5C3, 1'b0, "basic");
        run_a(16'h3C5A, 1'b1, "start_busy");

        // Abort during the 7th access's STROBE (accesses start every 5 cycles).
        @(negedge clk);
        clear_model_a(16'hFFFF);
        load_exp_a();
        p0 = bus_pulses_a;
        d0 = done_cnt_a;
        start_a = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_a = 1'b0;
        while (lat < 32) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("abort_in_strobe", sser_n_a, 0);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("abort_sser_n", sser_n_a, 1);
        check_eq("abort_bus_clk", bus_clk_a, 0);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_ba12", ba12_a, 0);
        rst_a = 1'b0;
        repeat (120) @(negedge clk);
        check_eq("abort_accesses", bus_pulses_a - p0, 6);
        check_eq("abort_no_done", done_cnt_a - d0, 0);
        exp_q.delete();
        run_a(16'h0F81, 1'b0, "after_abort");

        // start coincident with rst: reset wins.
        @(negedge clk);
        p0 = bus_pulses_a;
        rst_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        start_a = 1'b0;
        check_eq("rst_start_busy", busy_a, 0);
        repeat (10) @(negedge clk);
        check_eq("rst_start_pulses", bus_pulses_a - p0, 0);

        run_b(1'b1, "corner_one");
        run_b(1'b0, "corner_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
